alu_result_buffer: RTL
======================

Name: alu_result_buffer

Overview:
- Downstream stage of the N-bit combinational ALU. It captures each ALU result word, its five status flags and the opcode that produced it into a DEPTH-entry synchronous FIFO.
- The FIFO drains to the consumer (register file / CDC synchronizer input) over a valid/ready handshake.
- It also keeps sticky carry/overflow status for software polling.
- Optionally discards NOP (opcode 4'b1111) results.

Parameters:
- N, 8, ALU data width; must be >= 1.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- DROP_NOP, 1, 1 = accepted beats with opcode 4'b1111 are not stored; 0 = stored like any other.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer offers a result this cycle.
- in_ready  output  1  buffer can accept; equals !full (no combinational path from out_ready).
- in_data  input  N  ALU result.
- in_opcode  input  4  opcode that produced in_data.
- in_zero, in_carry, in_overflow, in_sign, in_equal  input  1 each  ALU flags.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes head entry.
- out_data  output  N  head result.
- out_opcode  output  4  head opcode.
- out_flags  output  5  head flags, packed {equal, sign, overflow, carry, zero} (bit4..bit0).
- count  output  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- sticky_carry  output  1  set by any stored beat with carry=1.
- sticky_overflow  output  1  set by any stored beat with overflow=1.
- sticky_clear  input  1  clears both sticky bits.

Behaviour:
- Reset (rst=1 at clk edge):
  - count=0; rd/wr pointers=0.
  - out_valid=0, in_ready=1.
  - sticky_carry=0, sticky_overflow=0.
  - out_data/out_opcode/out_flags read as 0.
  - Reset mid-operation discards all entries; reset wins over every other input.
- Push and pop conditions:
  - accept = in_valid & in_ready.
  - push = accept & !(DROP_NOP & in_opcode==4'b1111).
  - pop = out_valid & out_ready.
- Latency: a pushed entry appears on out_* the cycle after the push edge. There is no same-cycle bypass; an empty FIFO keeps out_valid=0 during the push cycle.
- out_* show the entry at rd_ptr and are stable while out_valid=1 and out_ready=0.
- out_* must not change after a pop except to present the next entry.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH naturally.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push & pop together.
- Full (count==DEPTH): in_ready=0.
  - A same-cycle pop does not raise in_ready that cycle.
  - in_ready returns 1 the cycle after the pop.
- Empty (count==0): out_valid=0; out_ready ignored.
- in_valid while in_ready=0: no effect. The producer must hold the data; the block drops nothing.
- Dropped NOP: accept is asserted (handshake completes) but count, pointers and sticky bits are unchanged.
- Sticky bits:
  - next = (sticky & !sticky_clear) | (push & flag).
  - A set on the same edge as sticky_clear wins.
- out_valid == (count != 0), registered-equivalent (derived from registered count).

Decomposition:
- Shared package alu_pkg:
  - opcode localparams OP_ADD..OP_NOP (4'b0000..4'b1111).
  - flag index constants FLAG_ZERO=0, FLAG_CARRY=1, FLAG_OVERFLOW=2, FLAG_SIGN=3, FLAG_EQUAL=4, FLAG_W=5.
  - packed struct alu_flags_t in the same bit order.
- One sub-module, fifo_ptr_ctrl #(DEPTH):
  - owns rd/wr pointers, count, full and empty from push/pop.
  - storage array and sticky logic stay in the top.

Test Plan:
- Reset, then push in_data=8'h3C, opcode=0000, carry=1 -> next cycle out_valid=1, out_data=8'h3C, out_flags=5'b00010, count=1, sticky_carry=1.
- Push 4 beats 8'h01..8'h04 with out_ready=0 -> count=4, in_ready=0. A 5th beat held 3 cycles is not taken. Drain -> 01,02,03,04 in order, then out_valid=0.
- Full FIFO with in_valid=1 and out_ready=1 for 1 cycle -> pop occurs, no push, count=3. Next cycle in_ready=1 and the held beat is pushed.
- Continuous push & pop at count=2 for 10 cycles -> count stays 2, pointers wrap past DEPTH, ordering preserved.
- DROP_NOP=1, accept opcode=1111 with overflow=1 -> in_ready handshake completes, count unchanged, sticky_overflow=0. With DROP_NOP=0 -> stored, sticky_overflow=1.
- sticky_clear=1 on the same edge as a push with carry=1 -> sticky_carry=1. sticky_clear alone next cycle -> 0. rst asserted with count=3 -> count=0, out_valid=0 on the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU datapath and its result buffer.
//   - opcode encodings OP_ADD..OP_NOP
//   - flag bit indices and the packed flag struct (bit4..bit0 =
//     equal, sign, overflow, carry, zero)
//   - pack_flags helper that builds the struct from individual flag wires
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_SAR  = 4'b1000;
  localparam logic [3:0] OP_ROL  = 4'b1001;
  localparam logic [3:0] OP_ROR  = 4'b1010;
  localparam logic [3:0] OP_INC  = 4'b1011;
  localparam logic [3:0] OP_DEC  = 4'b1100;
  localparam logic [3:0] OP_CMP  = 4'b1101;
  localparam logic [3:0] OP_PASS = 4'b1110;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_CARRY    = 1;
  localparam int FLAG_OVERFLOW = 2;
  localparam int FLAG_SIGN     = 3;
  localparam int FLAG_EQUAL    = 4;
  localparam int FLAG_W        = 5;

  typedef struct packed {
    logic equal;
    logic sign;
    logic overflow;
    logic carry;
    logic zero;
  } alu_flags_t;

  function automatic alu_flags_t pack_flags(input logic zero, input logic carry,
                                            input logic overflow, input logic sign,
                                            input logic equal);
    alu_flags_t f;
    f.zero     = zero;
    f.carry    = carry;
    f.overflow = overflow;
    f.sign     = sign;
    f.equal    = equal;
    return f;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers and occupancy for a DEPTH-entry FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   push, pop    : qualified write / read strobes (caller never pushes when
//                  full nor pops when empty)
//   wr_ptr       : slot written by a push this cycle
//   rd_ptr_next  : head slot after this edge (lets the caller preload the head)
//   count        : registered occupancy, 0..DEPTH
//   count_next   : occupancy after this edge
//   full, empty  : decoded from the registered count
module fifo_ptr_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [$clog2(DEPTH)-1:0] rd_ptr_next,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] wr_ptr_next_s;
  logic [CW-1:0] count_r;

  // Next-state for pointers and occupancy; pointers wrap modulo DEPTH by width
  always_comb begin
    rd_ptr_next   = rd_ptr_r;
    wr_ptr_next_s = wr_ptr_r;
    count_next    = count_r;
    if (pop) begin
      rd_ptr_next = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_next = rd_ptr_r;
    end
    if (push) begin
      wr_ptr_next_s = wr_ptr_r + AW'(1'b1);
    end else begin
      wr_ptr_next_s = wr_ptr_r;
    end
    case ({push, pop})
      2'b10:   count_next = count_r + CW'(1'b1);
      2'b01:   count_next = count_r - CW'(1'b1);
      default: count_next = count_r;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      rd_ptr_r <= rd_ptr_next;
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next;
    end
  end

  assign wr_ptr = wr_ptr_r;
  assign count  = count_r;
  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == '0);

endmodule

// File: rtl/alu_result_buffer.sv
// alu_result_buffer: FIFO that captures ALU result, flags and opcode and
// drains them over a valid/ready handshake, with sticky carry/overflow.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready             : producer handshake (in_ready = !full)
//   in_data, in_opcode, in_<flag> : ALU result beat
//   out_valid/out_ready           : consumer handshake (out_valid = count!=0)
//   out_data, out_opcode          : head entry
//   out_flags                     : head flags {equal,sign,overflow,carry,zero}
//   count                         : occupied entries 0..DEPTH
//   sticky_carry/overflow         : set by any stored beat with that flag
//   sticky_clear                  : clears both sticky bits (a set wins)
// With DROP_NOP=1 an accepted OP_NOP beat completes the handshake but is not
// stored and does not touch the sticky bits.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int N        = 8,
  parameter int DEPTH    = 4,
  parameter bit DROP_NOP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N-1:0]           in_data,
  input  logic [3:0]             in_opcode,
  input  logic                   in_zero,
  input  logic                   in_carry,
  input  logic                   in_overflow,
  input  logic                   in_sign,
  input  logic                   in_equal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N-1:0]           out_data,
  output logic [3:0]             out_opcode,
  output logic [FLAG_W-1:0]      out_flags,
  output logic [$clog2(DEPTH):0] count,
  output logic                   sticky_carry,
  output logic                   sticky_overflow,
  input  logic                   sticky_clear
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic            accept_s;
  logic            push_s;
  logic            pop_s;
  logic            full_s;
  logic            empty_s;
  logic [AW-1:0]   wr_ptr_s;
  logic [AW-1:0]   rd_ptr_next_s;
  logic [CW-1:0]   count_s;
  logic [CW-1:0]   count_next_s;
  alu_flags_t      in_flags_s;

  logic [N-1:0]    mem_data_r   [DEPTH];
  logic [3:0]      mem_opcode_r [DEPTH];
  alu_flags_t      mem_flags_r  [DEPTH];

  logic [N-1:0]    head_data_r;
  logic [3:0]      head_opcode_r;
  alu_flags_t      head_flags_r;
  logic            sticky_carry_r;
  logic            sticky_overflow_r;

  assign in_flags_s = pack_flags(in_zero, in_carry, in_overflow, in_sign, in_equal);
  assign accept_s   = in_valid & ~full_s;
  assign push_s     = accept_s & ~(DROP_NOP & (in_opcode == OP_NOP));
  assign pop_s      = ~empty_s & out_ready;

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .pop         (pop_s),
    .wr_ptr      (wr_ptr_s),
    .rd_ptr_next (rd_ptr_next_s),
    .count       (count_s),
    .count_next  (count_next_s),
    .full        (full_s),
    .empty       (empty_s)
  );

  // Storage write; contents need no reset because the head register is cleared
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_data_r[wr_ptr_s]   <= in_data;
      mem_opcode_r[wr_ptr_s] <= in_opcode;
      mem_flags_r[wr_ptr_s]  <= in_flags_s;
    end
  end

  // Registered head: preload the slot that will be at rd_ptr after this edge.
  // That slot is being written this edge only when the FIFO is empty after the
  // pop, so the incoming beat is forwarded into the head register then.
  // With nothing left the head holds, so outputs never glitch after a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_data_r   <= '0;
      head_opcode_r <= '0;
      head_flags_r  <= '0;
    end else if (count_next_s != '0) begin
      if (push_s && (wr_ptr_s == rd_ptr_next_s)) begin
        head_data_r   <= in_data;
        head_opcode_r <= in_opcode;
        head_flags_r  <= in_flags_s;
      end else begin
        head_data_r   <= mem_data_r[rd_ptr_next_s];
        head_opcode_r <= mem_opcode_r[rd_ptr_next_s];
        head_flags_r  <= mem_flags_r[rd_ptr_next_s];
      end
    end
  end

  // Sticky status: a set on the same edge as a clear takes priority
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_carry_r    <= 1'b0;
      sticky_overflow_r <= 1'b0;
    end else begin
      sticky_carry_r    <= (sticky_carry_r & ~sticky_clear) | (push_s & in_carry);
      sticky_overflow_r <= (sticky_overflow_r & ~sticky_clear) | (push_s & in_overflow);
    end
  end

  assign in_ready        = ~full_s;
  assign out_valid       = ~empty_s;
  assign out_data        = head_data_r;
  assign out_opcode      = head_opcode_r;
  assign out_flags       = head_flags_r;
  assign count           = count_s;
  assign sticky_carry    = sticky_carry_r;
  assign sticky_overflow = sticky_overflow_r;

endmodule
